seq_pattern_tx: RTL and testbench
=================================

Name: seq_pattern_tx

Overview:
Serial pattern transmitter: on request, drives a fixed PAT_W-bit pattern MSB-first onto a 1-bit data line, repeated a programmable number of times with an optional idle gap between repetitions. It is the stimulus/transmit end for the team's serial sequence detectors. With PATTERN=1010 and gap 0 it produces back-to-back overlapping 1010 frames. Data is qualified by dout_valid, with frame and completion pulses for bench and system control.

Parameters:
PAT_W, 4, pattern length in bits (2..16)
PATTERN, 4'b1010, pattern transmitted MSB first; width PAT_W
CNT_W, 8, width of repeat count
GAP_W, 4, width of inter-frame gap length

Ports:
clk  in  1  clock, rising edge
rst  in  1  synchronous, active-high reset
start  in  1  request; sampled only in IDLE
repeat_n  in  CNT_W  number of pattern repetitions; latched when start is accepted
gap_len  in  GAP_W  idle cycles between repetitions; latched when start is accepted
dout  out  1  serial data; 0 whenever dout_valid=0
dout_valid  out  1  dout carries a pattern bit this cycle
frame_end  out  1  high in the cycle carrying the last (LSB) bit of each repetition
busy  out  1  high from the first cycle after acceptance until done
done  out  1  one-cycle pulse at end of a request

Behaviour:
- Clock clk; reset rst is synchronous and active-high. All outputs are registered.
- Reset values: all outputs 0, state IDLE, counters 0. Reset wins over every other input.
- States: IDLE, SEND, GAP, DONE.
- IDLE:
  - start=1 with repeat_n!=0 accepts the request: latch repeat_n and gap_len, bit index = PAT_W-1, go to SEND.
  - start=1 with repeat_n==0 goes to DONE; no bits are sent.
- Latency: if start is accepted in cycle 0, cycle 1 has dout=PATTERN[PAT_W-1], dout_valid=1, busy=1.
- SEND: one bit per cycle, index decrementing. On the cycle carrying index 0:
  - frame_end=1 and the repetition counter decrements.
  - If repetitions remain and gap_len!=0, go to GAP.
  - If repetitions remain and gap_len==0, the next cycle carries PATTERN[PAT_W-1] again. Output is continuous, with no bubble.
  - If this was the last repetition, go to DONE.
- GAP: exactly gap_len cycles with dout=0, dout_valid=0, busy=1; then SEND from index PAT_W-1.
- DONE: one cycle with done=1, busy=0, dout_valid=0; then IDLE. start during DONE is ignored.
- start while busy or in DONE is ignored; latched parameters do not change mid-request.
- Changing repeat_n or gap_len inputs after acceptance has no effect.
- Reset mid-request: the next cycle is IDLE with all outputs 0. No done pulse is issued.
- Total request length: repeat_n*PAT_W + (repeat_n-1)*gap_len cycles of busy, then 1 cycle of done.
- Maximum repeat_n = 2^CNT_W-1; the counter never wraps.

Decomposition:
- Shared package seq_pkg:
  - tx state enum (IDLE/SEND/GAP/DONE)
  - default pattern constants (PAT_1010, PAT_1011, PAT_W_DEFAULT)
  - so that future detectors and transmitters share the same encodings.
- Natural sub-module pat_serializer: holds the PAT_W-bit shift/index logic. It has a load input, an advance input, and outputs bit and last.
- seq_pattern_tx keeps the FSM, repeat counter and gap counter.

Test Plan:
- Reset, then start=1, repeat_n=2, gap_len=0:
  - dout = 1,0,1,0,1,0,1,0 in cycles 1-8, dout_valid=1 throughout.
  - frame_end in cycles 4 and 8; done in cycle 9; busy low from cycle 9.
- start, repeat_n=2, gap_len=2:
  - cycles 1-4 carry 1010; cycles 5-6 have dout_valid=0, dout=0; cycles 7-10 carry 1010.
  - done in cycle 11.
- start with repeat_n=0 -> no dout_valid; done=1 in cycle 1; busy stays 0.
- start held high during a repeat_n=3 request, with repeat_n and gap_len changed mid-request:
  - stream is unchanged (12 bits), exactly one done pulse.
  - a new request is accepted only from the cycle after done.
- rst asserted in cycle 3 of a repeat_n=5 request -> next cycle all outputs 0 and IDLE; no done pulse; a fresh start is accepted normally.
- Loopback into a bench 1010 overlapping detector model, repeat_n=3, gap 0 -> detector fires 5 times (1 per frame plus 2 overlaps). With gap_len=1 it fires 3 times.

Source files
------------

// File: rtl/seq_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : seq_pkg
//  Brief    : Shared encodings for serial sequence transmitters and detectors.
//  Revision : 1.0 - initial release
// ============================================================================
package seq_pkg;

  // Transmit FSM states, shared so detectors and benches decode them alike
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_SEND = 2'd1,
    ST_GAP  = 2'd2,
    ST_DONE = 2'd3
  } tx_state_t;

  // Default pattern set
  localparam int         PAT_W_DEFAULT = 4;
  localparam logic [3:0] PAT_1010      = 4'b1010;
  localparam logic [3:0] PAT_1011      = 4'b1011;

endpackage : seq_pkg
`default_nettype wire

// File: rtl/pat_serializer.sv
`default_nettype none
// ============================================================================
//  Module   : pat_serializer
//  Brief    : Emits a fixed pattern MSB-first, one registered bit per cycle.
//             load emits the MSB; advance emits the next bit and wraps from
//             the LSB straight back to the MSB so frames can run gap-free.
//             With neither request the outputs drop to 0.
//  Revision : 1.0 - initial release
// ============================================================================
module pat_serializer
  import seq_pkg::*;
#(
  parameter int             PAT_W   = PAT_W_DEFAULT,
  parameter logic [PAT_W-1:0] PATTERN = PAT_1010
) (
  input  logic clk,
  input  logic rst,
  input  logic load,     // emit the MSB next cycle
  input  logic advance,  // emit the pending bit next cycle
  output logic dbit,     // pattern bit on the line this cycle
  output logic last      // this cycle carries the LSB
);

  localparam int IW = (PAT_W > 1) ? $clog2(PAT_W) : 1;

  // Index of the bit that the next advance will emit
  logic [IW-1:0] idx;

  // Emit one bit per request and keep the pending index up to date
  always_ff @(posedge clk) begin
    if (rst) begin
      idx  <= '0;
      dbit <= 1'b0;
      last <= 1'b0;
    end else if (load) begin
      dbit <= PATTERN[PAT_W-1];
      last <= 1'b0;
      idx  <= IW'(PAT_W - 2);
    end else if (advance) begin
      dbit <= PATTERN[idx];
      last <= (idx == '0);
      idx  <= (idx == '0) ? IW'(PAT_W - 1) : idx - 1'b1;
    end else begin
      dbit <= 1'b0;
      last <= 1'b0;
    end
  end

endmodule : pat_serializer
`default_nettype wire

// File: rtl/seq_pattern_tx.sv
`default_nettype none
// ============================================================================
//  Module   : seq_pattern_tx
//  Brief    : Serial pattern transmitter. Sends PATTERN MSB-first repeat_n
//             times with gap_len idle cycles between repetitions, then pulses
//             done. All outputs are registered.
//  Revision : 1.0 - initial release
// ============================================================================
module seq_pattern_tx
  import seq_pkg::*;
#(
  parameter int               PAT_W   = PAT_W_DEFAULT,
  parameter logic [PAT_W-1:0] PATTERN = PAT_1010,
  parameter int               CNT_W   = 8,
  parameter int               GAP_W   = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [CNT_W-1:0] repeat_n,
  input  logic [GAP_W-1:0] gap_len,
  output logic             dout,
  output logic             dout_valid,
  output logic             frame_end,
  output logic             busy,
  output logic             done
);

  tx_state_t        state;
  logic [CNT_W-1:0] rep_cnt;   // repetitions still to finish, incl. current
  logic [GAP_W-1:0] gap_lat;   // gap length captured at acceptance
  logic [GAP_W-1:0] gap_cnt;   // gap cycles left, incl. current
  logic             ser_load;
  logic             ser_adv;
  logic             ser_last;

  wire last_rep = (rep_cnt == CNT_W'(1));

  // Decide which bit, if any, the serializer puts on the line next cycle
  always_comb begin
    ser_load = 1'b0;
    ser_adv  = 1'b0;
    case (state)
      ST_IDLE: ser_load = start && (repeat_n != '0);
      ST_SEND: ser_adv  = !ser_last || (!last_rep && (gap_lat == '0));
      ST_GAP:  ser_load = (gap_cnt == GAP_W'(1));
      default: ;
    endcase
  end

  pat_serializer #(
    .PAT_W   (PAT_W),
    .PATTERN (PATTERN)
  ) u_ser (
    .clk     (clk),
    .rst     (rst),
    .load    (ser_load),
    .advance (ser_adv),
    .dbit    (dout),
    .last    (ser_last)
  );

  assign frame_end = ser_last;

  // Request FSM with repeat/gap counters and registered status outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= ST_IDLE;
      rep_cnt    <= '0;
      gap_lat    <= '0;
      gap_cnt    <= '0;
      dout_valid <= 1'b0;
      busy       <= 1'b0;
      done       <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (start) begin
            if (repeat_n != '0) begin
              rep_cnt    <= repeat_n;
              gap_lat    <= gap_len;
              busy       <= 1'b1;
              dout_valid <= 1'b1;
              state      <= ST_SEND;
            end else begin
              done  <= 1'b1;
              state <= ST_DONE;
            end
          end
        end
        ST_SEND: begin
          if (ser_last) begin
            rep_cnt <= rep_cnt - 1'b1;
            if (last_rep) begin
              done       <= 1'b1;
              busy       <= 1'b0;
              dout_valid <= 1'b0;
              state      <= ST_DONE;
            end else if (gap_lat != '0) begin
              gap_cnt    <= gap_lat;
              dout_valid <= 1'b0;
              state      <= ST_GAP;
            end
          end
        end
        ST_GAP: begin
          if (gap_cnt == GAP_W'(1)) begin
            dout_valid <= 1'b1;
            state      <= ST_SEND;
          end else begin
            gap_cnt <= gap_cnt - 1'b1;
          end
        end
        ST_DONE: state <= ST_IDLE;
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule : seq_pattern_tx
`default_nettype wire

// File: tb/tb_seq_pattern_tx.sv
`default_nettype none
// ============================================================================
//  Module   : tb_seq_pattern_tx
//  Brief    : Directed self-checking bench for seq_pattern_tx. Per-cycle
//             outputs are packed into vectors (cycle 1 in the MSB) and compared
//             against hand-computed expectations; a 1010 overlapping detector
//             model consumes the dout stream.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_seq_pattern_tx;

  logic       clk = 1'b0;
  logic       rst;
  logic       start;
  logic [7:0] repeat_n;
  logic [3:0] gap_len;
  logic       dout, dout_valid, frame_end, busy, done;

  int checks = 0;
  int errors = 0;

  seq_pattern_tx #(
    .PAT_W   (4),
    .PATTERN (4'b1010),
    .CNT_W   (8),
    .GAP_W   (4)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .repeat_n   (repeat_n),
    .gap_len    (gap_len),
    .dout       (dout),
    .dout_valid (dout_valid),
    .frame_end  (frame_end),
    .busy       (busy),
    .done       (done)
  );

  always #5 clk = ~clk;

  // Compare one observed value against its expectation
  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %b expected %b", tag, obs, exp);
    end
  endtask

  // Present a request on the next falling edge; accepted at the following rising edge
  task automatic kick(input logic [7:0] rep, input logic [3:0] gap);
    @(negedge clk);
    start    = 1'b1;
    repeat_n = rep;
    gap_len  = gap;
  endtask

  // Sample n cycles of outputs; optionally keep start high and alter inputs mid-run
  task automatic capture(input int n, input bit hold, input int chg_at,
                         input logic [7:0] chg_rep, input logic [3:0] chg_gap,
                         output logic [31:0] vd, output logic [31:0] vv,
                         output logic [31:0] vf, output logic [31:0] vb,
                         output logic [31:0] vdn, output int det);
    logic [3:0] hist;
    hist = '0; vd = '0; vv = '0; vf = '0; vb = '0; vdn = '0; det = 0;
    for (int i = 1; i <= n; i++) begin
      @(negedge clk);
      vd  = {vd[30:0],  dout};
      vv  = {vv[30:0],  dout_valid};
      vf  = {vf[30:0],  frame_end};
      vb  = {vb[30:0],  busy};
      vdn = {vdn[30:0], done};
      hist = {hist[2:0], dout};
      if (hist == 4'b1010) det++;
      if (!hold) start = 1'b0;
      if (i == chg_at) begin
        repeat_n = chg_rep;
        gap_len  = chg_gap;
      end
    end
  endtask

  logic [31:0] vd, vv, vf, vb, vdn;
  int          det;

  initial begin
    rst = 1'b1; start = 1'b0; repeat_n = '0; gap_len = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("reset_outputs", {27'd0, dout, dout_valid, frame_end, busy, done}, 32'd0);
    rst = 1'b0;

    // repeat 2, no gap: continuous 10101010, done in cycle 9
    kick(8'd2, 4'd0);
    capture(10, 1'b0, -1, 8'd0, 4'd0, vd, vv, vf, vb, vdn, det);
    check("r2g0_dout",  vd,  32'b1010101000);
    check("r2g0_valid", vv,  32'b1111111100);
    check("r2g0_fend",  vf,  32'b0001000100);
    check("r2g0_busy",  vb,  32'b1111111100);
    check("r2g0_done",  vdn, 32'b0000000010);
    check("r2g0_det",   det, 32'd3);

    // repeat 2, gap 2: frames at 1-4 and 7-10, done in cycle 11
    kick(8'd2, 4'd2);
    capture(12, 1'b0, -1, 8'd0, 4'd0, vd, vv, vf, vb, vdn, det);
    check("r2g2_dout",  vd,  32'b101000101000);
    check("r2g2_valid", vv,  32'b111100111100);
    check("r2g2_fend",  vf,  32'b000100000100);
    check("r2g2_busy",  vb,  32'b111111111100);
    check("r2g2_done",  vdn, 32'b000000000010);

    // repeat 0: immediate done, never busy
    kick(8'd0, 4'd3);
    capture(3, 1'b0, -1, 8'd0, 4'd0, vd, vv, vf, vb, vdn, det);
    check("r0_dout",  vd,  32'b000);
    check("r0_valid", vv,  32'b000);
    check("r0_fend",  vf,  32'b000);
    check("r0_busy",  vb,  32'b000);
    check("r0_done",  vdn, 32'b100);

    // repeat 3 with start held and inputs changed in cycle 2; re-accept in cycle 14
    kick(8'd3, 4'd0);
    capture(15, 1'b1, 2, 8'd1, 4'd3, vd, vv, vf, vb, vdn, det);
    check("hold_dout",  vd,  32'b101010101010001);
    check("hold_valid", vv,  32'b111111111111001);
    check("hold_fend",  vf,  32'b000100010001000);
    check("hold_busy",  vb,  32'b111111111111001);
    check("hold_done",  vdn, 32'b000000000000100);
    // second request uses the values present at re-acceptance: repeat 1
    capture(5, 1'b0, -1, 8'd0, 4'd0, vd, vv, vf, vb, vdn, det);
    check("hold2_dout", vd,  32'b01000);
    check("hold2_done", vdn, 32'b00010);

    // reset in cycle 3 of a repeat 5 request
    kick(8'd5, 4'd0);
    capture(2, 1'b0, -1, 8'd0, 4'd0, vd, vv, vf, vb, vdn, det);
    check("rst_pre_busy", vb, 32'b11);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    check("rst_outputs", {27'd0, dout, dout_valid, frame_end, busy, done}, 32'd0);
    rst = 1'b0;
    capture(10, 1'b0, -1, 8'd0, 4'd0, vd, vv, vf, vb, vdn, det);
    check("rst_no_done",  vdn, 32'd0);
    check("rst_no_valid", vv,  32'd0);
    kick(8'd1, 4'd0);
    capture(6, 1'b0, -1, 8'd0, 4'd0, vd, vv, vf, vb, vdn, det);
    check("rst_fresh_dout", vd,  32'b101000);
    check("rst_fresh_done", vdn, 32'b000010);

    // loopback into the overlapping 1010 detector model
    kick(8'd3, 4'd0);
    capture(14, 1'b0, -1, 8'd0, 4'd0, vd, vv, vf, vb, vdn, det);
    check("loop_g0_det", det, 32'd5);
    kick(8'd3, 4'd1);
    capture(16, 1'b0, -1, 8'd0, 4'd0, vd, vv, vf, vb, vdn, det);
    check("loop_g1_det", det, 32'd3);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule : tb_seq_pattern_tx
`default_nettype wire
